dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the pipeline data-memory interface; the MEM stage is the initiator.
- Accepts one load or store request described by addr, rmask, wmask and wdata. Returns rdata and a one-cycle resp after a fixed latency.
- Backed by an internal word-wide storage array.
- Used as the dmem target in pipeline simulation and as a drop-in stand-in for the cache.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in storage (power of two)
LATENCY, 2, cycles from request acceptance to resp; legal range 1..15
BASE_ADDR, 32'h1eceb000, byte address of word 0; must be 4-byte aligned

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
dmem_addr  in  32  request byte address; bits [1:0] ignored (word-granular)
dmem_rmask  in  4  byte-lane read enables; nonzero means read request
dmem_wmask  in  4  byte-lane write enables; nonzero means write request
dmem_wdata  in  32  write data, lane-aligned
dmem_rdata  out  32  read data, registered, lane-aligned
dmem_resp  out  1  one-cycle completion pulse
dmem_err  out  1  qualifies dmem_resp: request was out of range or illegal
init_we  in  1  backdoor word write, for bench preload
init_addr  in  32  backdoor byte address
init_wdata  in  32  backdoor data

Behaviour:
- Reset (async, any cycle):
  - state to IDLE, count to 0.
  - dmem_resp, dmem_err to 0; dmem_rdata to 32'h0.
  - Storage contents are not reset.
  - Reset mid-transaction drops the request with no response and no write. A write already committed stays.
- State machine:
  - IDLE: a request is present when (rmask | wmask) != 0. On the edge that samples it, latch the request, load count = LATENCY-1, go to WAIT. If LATENCY==1, go directly to RESP.
  - WAIT: decrement count each cycle. When count==1, next state is RESP. Requests presented in WAIT are ignored; the initiator holds them stable until resp by contract.
  - RESP: dmem_resp=1 for exactly this cycle. A request present in this cycle is accepted as a new transaction (back-to-back, same transitions as IDLE); otherwise return to IDLE.
- Latency: request sampled at edge T gives dmem_resp high in the cycle after edge T+LATENCY-1. Minimum throughput is one transaction per LATENCY cycles.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2.
  - In range iff addr >= BASE_ADDR and index < DEPTH_WORDS. Compute the subtraction unsigned at 32 bits.
- Write:
  - Committed at the acceptance edge: each lane i with wmask[i] takes wdata[8i+7:8i]. Other lanes are unchanged.
  - A later read sees the write.
- Read:
  - Storage word captured at the acceptance edge and held until RESP.
  - dmem_rdata presents the full word in the RESP cycle; lane selection is the initiator's job.
  - dmem_rdata holds its last value outside RESP.
- Error: out of range, or rmask and wmask both nonzero, gives:
  - no write;
  - dmem_rdata = 32'h0 in RESP;
  - dmem_err = 1 in the RESP cycle only.
- Backdoor:
  - init_we writes a full word at the decoded index the same edge; out of range is ignored.
  - init_we has priority over a same-index request write in the same cycle.
  - Bench uses it only while no transaction is outstanding.
- Assertions:
  - dmem_resp never high for two consecutive cycles unless back-to-back.
  - Request signals stable while in WAIT.

Decomposition:
- The state enum (dmem_resp_state_t: IDLE, WAIT, RESP) goes into the shared rv32i_types package. It sits there beside the existing mask and load/store op typedefs, which this block reuses.
- One natural sub-module: dmem_store_array, a byte-lane-masked synchronous word RAM with one port plus the backdoor port. Address decode, the latency counter and the FSM stay in dmem_responder.

Test Plan:
- Reset: assert rst mid-WAIT after a write to 0x1eceb010 was accepted -> dmem_resp stays 0 through and after reset; dmem_rdata=0. A later read of 0x1eceb010 returns the written word (write was committed).
- Store/load: LATENCY=2. Write wmask=4'b1111, wdata=32'hDEADBEEF at 0x1eceb004 -> resp 2 cycles after acceptance, err=0. Then read rmask=4'b1111 -> rdata=32'hDEADBEEF.
- Byte lanes: preload word 0 with 32'h11223344 via init. Write wmask=4'b0100, wdata=32'h00AA0000 -> a read returns 32'h11AA3344.
- Back-to-back: a request held present in the RESP cycle is accepted immediately. Two reads give resp pulses exactly LATENCY cycles apart with correct data each.
- Errors, each -> resp with err=1, rdata=0, and storage unchanged:
  - addr=0x1eceaffc (below base);
  - addr=BASE+4*DEPTH_WORDS;
  - rmask=4'b0001 together with wmask=4'b0001.
- LATENCY=1 build: a read accepted at edge T -> resp in the cycle immediately after T. Ten consecutive reads complete in 10 cycles.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: byte masks, load/store ops, and the dmem responder
// state and request records.
package rv32i_types;

    typedef logic [3:0] mask_t;

    typedef enum logic [2:0] {
        LS_B,
        LS_H,
        LS_W,
        LS_BU,
        LS_HU
    } load_store_op_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_resp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        mask_t       rmask;
        mask_t       wmask;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam int unsigned LANES = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline data-memory bus between the MEM stage (master) and a memory target
// (slave).
interface dmem_responder_if;
    import rv32i_types::*;

    logic [31:0] dmem_addr;
    mask_t       dmem_rmask;
    mask_t       dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;

    modport master (
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_err
    );

    modport slave (
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_err
    );

endinterface

// File: rtl/dmem_store_array.sv
// Single-port word RAM with byte-lane write enables, a registered read capture and
// a full-word backdoor write port that wins over the normal port.
module dmem_store_array
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  mask_t            wmask,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic             rzero,
    output logic [31:0]      rd_word,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_idx,
    input  logic [31:0]      init_wdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset branch; clearing a RAM on reset cannot map onto
    // block memory, so contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        // Issued last so it overrides a same-index lane write in this cycle.
        if (init_we) mem[init_idx] <= init_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word <= '0;
        end else if (re) begin
            rd_word <= rzero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency responder for the pipeline data-memory bus: decodes the request,
// commits stores at acceptance and returns a one-cycle resp LATENCY cycles later.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h1eceb000
) (
    input  logic                clk,
    input  logic                rst,
    dmem_responder_if.slave     bus,
    input  logic                init_we,
    input  logic [31:0]         init_addr,
    input  logic [31:0]         init_wdata
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    dmem_resp_state_t state, state_d;
    logic [3:0]       count, count_d;
    logic             accept;
    logic             err_q;
    dmem_req_t        req_q;
    logic [31:0]      rd_word;

    // Offsets are unsigned 32-bit so addresses below the base wrap high and fail.
    logic [31:0] req_off, init_off;
    logic        req_in_range, init_in_range, req_present, illegal, store;
    logic        unused_ok;

    assign req_off       = bus.dmem_addr - BASE_ADDR;
    assign init_off      = init_addr - BASE_ADDR;
    assign req_in_range  = (bus.dmem_addr >= BASE_ADDR) &&
                           ({2'b00, req_off[31:2]} < 32'(DEPTH_WORDS));
    assign init_in_range = (init_addr >= BASE_ADDR) &&
                           ({2'b00, init_off[31:2]} < 32'(DEPTH_WORDS));
    assign unused_ok     = ^{req_off[1:0], init_off[1:0]};

    assign req_present = |(bus.dmem_rmask | bus.dmem_wmask);
    assign illegal     = !req_in_range || ((|bus.dmem_rmask) && (|bus.dmem_wmask));
    assign store       = accept && !illegal && (|bus.dmem_wmask);

    // NOTE: every output of this block gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        count_d = count;
        accept  = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                state_d = IDLE;
                if (req_present) begin
                    accept  = 1'b1;
                    count_d = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                count_d = count - 4'd1;
                if (count == 4'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            err_q <= 1'b0;
            req_q <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            if (accept) begin
                err_q <= illegal;
                req_q <= '{addr: bus.dmem_addr, rmask: bus.dmem_rmask,
                           wmask: bus.dmem_wmask, wdata: bus.dmem_wdata};
            end
        end
    end

    assign bus.dmem_resp = (state == RESP);
    assign bus.dmem_err  = (state == RESP) && err_q;

    dmem_store_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_store (
        .clk        (clk),
        .rst        (rst),
        .we         (store),
        .wmask      (bus.dmem_wmask),
        .idx        (req_off[IDX_W+1:2]),
        .wdata      (bus.dmem_wdata),
        .re         (accept),
        .rzero      (illegal),
        .rd_word    (rd_word),
        .init_we    (init_we && init_in_range),
        .init_idx   (init_off[IDX_W+1:2]),
        .init_wdata (init_wdata)
    );

    // With one-cycle latency the capture register already is the RESP-cycle output;
    // otherwise a second register holds rdata steady until the WAIT->RESP edge.
    if (LATENCY == 1) begin : g_lat1
        assign bus.dmem_rdata = rd_word;
    end else begin : g_latn
        logic [31:0] rdata_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (state == WAIT && count == 4'd1) begin
                rdata_q <= rd_word;
            end
        end
        assign bus.dmem_rdata = rdata_q;
    end

    logic resp_q, accept_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q   <= 1'b0;
            accept_q <= 1'b0;
        end else begin
            resp_q   <= bus.dmem_resp;
            accept_q <= accept;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (state == WAIT) begin
                assert (bus.dmem_addr == req_q.addr && bus.dmem_rmask == req_q.rmask &&
                        bus.dmem_wmask == req_q.wmask && bus.dmem_wdata == req_q.wdata);
            end
            if (bus.dmem_resp && resp_q) assert (accept_q);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main scenarios and
// a LATENCY=1 instance for single-cycle streaming.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_we2, init_we1;
    logic [31:0] init_addr2, init_wdata2, init_addr1, init_wdata1;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus2 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(BASE)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .init_we(init_we2), .init_addr(init_addr2), .init_wdata(init_wdata2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .init_we(init_we1), .init_addr(init_addr1), .init_wdata(init_wdata1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload2(input logic [31:0] a, input logic [31:0] d);
        init_we2 = 1'b1; init_addr2 = a; init_wdata2 = d;
        step();
        init_we2 = 1'b0;
    endtask

    task automatic preload1(input logic [31:0] a, input logic [31:0] d);
        init_we1 = 1'b1; init_addr1 = a; init_wdata1 = d;
        step();
        init_we1 = 1'b0;
    endtask

    // One complete transaction on the LATENCY=2 instance, bounded at 20 cycles.
    task automatic req2(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int lat;
        bus2.dmem_addr = a; bus2.dmem_rmask = rm; bus2.dmem_wmask = wm; bus2.dmem_wdata = wd;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus2.dmem_resp && lat < 20);
        rd = bus2.dmem_rdata;
        er = bus2.dmem_err;
        bus2.dmem_rmask = 4'b0; bus2.dmem_wmask = 4'b0;
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL latency addr=%h: got %0d cycles, expected 2", a, lat);
        end
        step();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        rst = 1'b1;
        step();
        step();
        n_checks++; if (bus2.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b expected 0", bus2.dmem_resp); end
        n_checks++; if (bus2.dmem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus2.dmem_err); end
        n_checks++; if (bus2.dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus2.dmem_rdata); end
        n_checks++; if (bus1.dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_lat1: got %h expected 0", bus1.dmem_rdata); end
        rst = 1'b0;
        step();

        preload2(BASE + 32'h14, 32'h0000_0055);
        req2(BASE + 32'h14, 4'hf, 4'h0, 32'h0, rd, er);
        n_checks++; if (rd !== 32'h0000_0055) begin n_fail++; $display("FAIL pre_reset_read: got %h expected 00000055", rd); end

        bus2.dmem_addr = BASE + 32'h10; bus2.dmem_rmask = 4'h0;
        bus2.dmem_wmask = 4'hf; bus2.dmem_wdata = 32'hCAFE_F00D;
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (bus2.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL midwait_resp: got %b expected 0", bus2.dmem_resp); end
        n_checks++; if (bus2.dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL midwait_rdata: got %h expected 0", bus2.dmem_rdata); end
        bus2.dmem_wmask = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus2.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL in_reset_resp[%0d]: got %b expected 0", i, bus2.dmem_resp); end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus2.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL post_reset_resp[%0d]: got %b expected 0", i, bus2.dmem_resp); end
        end
        req2(BASE + 32'h10, 4'hf, 4'h0, 32'h0, rd, er);
        n_checks++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL committed_write: got %h expected cafef00d", rd); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        req2(BASE + 32'h4, 4'h0, 4'hf, 32'hDEAD_BEEF, rd, er);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
        req2(BASE + 32'h4, 4'hf, 4'h0, 32'h0, rd, er);
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_data: got %h expected deadbeef", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b expected 0", er); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er;
        preload2(BASE, 32'h1122_3344);
        req2(BASE, 4'h0, 4'b0100, 32'h00AA_0000, rd, er);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL lane_store_err: got %b expected 0", er); end
        req2(BASE, 4'hf, 4'h0, 32'h0, rd, er);
        n_checks++; if (rd !== 32'h11AA_3344) begin n_fail++; $display("FAIL lane_merge: got %h expected 11aa3344", rd); end
    endtask

    task automatic test_back_to_back();
        int lat;
        preload2(BASE + 32'h8, 32'hA5A5_0002);
        preload2(BASE + 32'hc, 32'h5A5A_0003);
        bus2.dmem_addr = BASE + 32'h8; bus2.dmem_rmask = 4'hf;
        bus2.dmem_wmask = 4'h0; bus2.dmem_wdata = 32'h0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus2.dmem_resp && lat < 20);
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 2", lat); end
        n_checks++; if (bus2.dmem_rdata !== 32'hA5A5_0002) begin n_fail++; $display("FAIL b2b_first_data: got %h expected a5a50002", bus2.dmem_rdata); end
        bus2.dmem_addr = BASE + 32'hc;
        step();
        n_checks++; if (bus2.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_resp: got %b expected 0", bus2.dmem_resp); end
        n_checks++; if (bus2.dmem_rdata !== 32'hA5A5_0002) begin n_fail++; $display("FAIL b2b_rdata_hold: got %h expected a5a50002", bus2.dmem_rdata); end
        step();
        n_checks++; if (bus2.dmem_resp !== 1'b1) begin n_fail++; $display("FAIL b2b_second_resp: got %b expected 1", bus2.dmem_resp); end
        n_checks++; if (bus2.dmem_rdata !== 32'h5A5A_0003) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 5a5a0003", bus2.dmem_rdata); end
        bus2.dmem_rmask = 4'h0;
        step();
        n_checks++; if (bus2.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got %b expected 0", bus2.dmem_resp); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        preload2(BASE + 32'hffc, 32'h0BAD_F00D);

        req2(32'h1eceaffc, 4'h0, 4'hf, 32'hFFFF_FFFF, rd, er);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL below_base_err: got %b expected 1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL below_base_rdata: got %h expected 0", rd); end
        req2(BASE + 32'hffc, 4'hf, 4'h0, 32'h0, rd, er);
        n_checks++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL below_base_nowrite: got %h expected 0badf00d", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL top_word_err: got %b expected 0", er); end

        req2(BASE + 32'h1000, 4'h0, 4'hf, 32'h1234_5678, rd, er);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL above_top_err: got %b expected 1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL above_top_rdata: got %h expected 0", rd); end
        req2(BASE, 4'hf, 4'h0, 32'h0, rd, er);
        n_checks++; if (rd !== 32'h11AA_3344) begin n_fail++; $display("FAIL above_top_nowrite: got %h expected 11aa3344", rd); end

        req2(BASE + 32'h4, 4'b0001, 4'b0001, 32'h0000_00FF, rd, er);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL rw_both_err: got %b expected 1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rw_both_rdata: got %h expected 0", rd); end
        req2(BASE + 32'h4, 4'hf, 4'h0, 32'h0, rd, er);
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_both_nowrite: got %h expected deadbeef", rd); end
    endtask

    task automatic test_latency1();
        for (int i = 0; i < 10; i++) preload1(BASE + 32'(4 * i), 32'hC0DE_0000 | 32'(i));
        bus1.dmem_addr = BASE; bus1.dmem_rmask = 4'hf;
        bus1.dmem_wmask = 4'h0; bus1.dmem_wdata = 32'h0;
        n_checks++; if (bus1.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL lat1_idle_resp: got %b expected 0", bus1.dmem_resp); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (bus1.dmem_resp !== 1'b1) begin n_fail++; $display("FAIL lat1_resp[%0d]: got %b expected 1", i, bus1.dmem_resp); end
            n_checks++; if (bus1.dmem_rdata !== (32'hC0DE_0000 | 32'(i))) begin n_fail++; $display("FAIL lat1_data[%0d]: got %h expected %h", i, bus1.dmem_rdata, 32'hC0DE_0000 | 32'(i)); end
            if (i < 9) bus1.dmem_addr = BASE + 32'(4 * (i + 1));
            else       bus1.dmem_rmask = 4'h0;
        end
        step();
        n_checks++; if (bus1.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL lat1_done_resp: got %b expected 0", bus1.dmem_resp); end
    endtask

    initial begin
        rst = 1'b1;
        init_we2 = 1'b0; init_addr2 = 32'h0; init_wdata2 = 32'h0;
        init_we1 = 1'b0; init_addr1 = 32'h0; init_wdata1 = 32'h0;
        bus2.dmem_addr = 32'h0; bus2.dmem_rmask = 4'h0; bus2.dmem_wmask = 4'h0; bus2.dmem_wdata = 32'h0;
        bus1.dmem_addr = 32'h0; bus1.dmem_rmask = 4'h0; bus1.dmem_wmask = 4'h0; bus1.dmem_wdata = 32'h0;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
